// File: rtl/apb_pkg.sv
// Shared definitions for the APB command master: default bus widths,
// the transfer FSM states and the default command layout.
package apb_pkg;

  localparam int DEF_AMBA_WORD       = 32;
  localparam int DEF_AMBA_ADDR_WIDTH = 20;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef struct packed {
    logic                           write;
    logic [DEF_AMBA_ADDR_WIDTH-1:0] addr;
    logic [DEF_AMBA_WORD-1:0]       wdata;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Registered command FIFO; full/empty come from extra pointer MSB,
// pointers wrap modulo 2*DEPTH.
module apb_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 53
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]      r_wr_ptr;
  logic [PW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_full;
  logic             w_empty;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                   (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (i_push && !w_full)  r_wr_ptr <= r_wr_ptr + 1'b1;
      if (i_pop  && !w_empty) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between the pointers.
  always_ff @(posedge clk) begin
    if (i_push && !w_full) r_mem[r_wr_ptr[PW-1:0]] <= i_push_data;
  end

  assign o_full  = w_full;
  assign o_empty = w_empty;
  assign o_head  = r_mem[r_rd_ptr[PW-1:0]];

endmodule

// File: rtl/apb_cmd_master.sv
// APB master fed by a command FIFO: each queued command becomes one
// two-cycle SETUP/ACCESS transfer, followed by a one-cycle response pulse.
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int AMBA_WORD       = DEF_AMBA_WORD,
  parameter int AMBA_ADDR_WIDTH = DEF_AMBA_ADDR_WIDTH,
  parameter int CMD_DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_write,
  input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [AMBA_WORD-1:0]       cmd_wdata,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  output logic [AMBA_WORD-1:0]       PWDATA,
  input  logic [AMBA_WORD-1:0]       PRDATA,
  output logic                       rsp_valid,
  output logic                       rsp_write,
  output logic [AMBA_WORD-1:0]       rsp_rdata,
  output logic                       busy,
  output logic [1:0]                 o_dbg_state
);

  typedef struct packed {
    logic                       write;
    logic [AMBA_ADDR_WIDTH-1:0] addr;
    logic [AMBA_WORD-1:0]       wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  // Handshake: a command transfers on a cycle where cmd_valid and cmd_ready
  // are both high; cmd_ready depends only on FIFO fullness and reset.
  cmd_t       w_push_cmd;
  cmd_t       w_head;
  logic       w_full;
  logic       w_empty;
  logic       w_cmd_ready;
  logic       w_push;
  logic       w_pop;
  apb_state_e r_state;
  apb_state_e w_next_state;

  logic [AMBA_ADDR_WIDTH-1:0] r_paddr;
  logic                       r_pwrite;
  logic [AMBA_WORD-1:0]       r_pwdata;
  logic                       r_rsp_valid;
  logic                       r_rsp_write;
  logic [AMBA_WORD-1:0]       r_rsp_rdata;

  assign w_cmd_ready = !w_full && !rst;
  assign w_push      = cmd_valid && w_cmd_ready;
  assign w_push_cmd  = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata};

  apb_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (w_push_cmd),
    .i_pop       (w_pop),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_head      (w_head)
  );

  // The head is popped on the edge that enters SETUP.
  always_comb begin
    w_next_state = r_state;
    w_pop        = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_empty) begin
          w_next_state = SETUP;
          w_pop        = 1'b1;
        end
      end
      SETUP:  w_next_state = ACCESS;
      ACCESS: begin
        if (!w_empty) begin
          w_next_state = SETUP;
          w_pop        = 1'b1;
        end else begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_paddr  <= '0;
      r_pwrite <= 1'b0;
      r_pwdata <= '0;
    end else if (w_pop) begin
      r_paddr  <= w_head.addr;
      r_pwrite <= w_head.write;
      r_pwdata <= w_head.wdata;
    end
  end

  // PRDATA is captured at the end of ACCESS; write responses carry zero data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      r_rsp_valid <= (r_state == ACCESS);
      r_rsp_write <= (r_state == ACCESS) && r_pwrite;
      r_rsp_rdata <= ((r_state == ACCESS) && !r_pwrite) ? PRDATA : '0;
    end
  end

  assign cmd_ready   = w_cmd_ready;
  assign PADDR       = r_paddr;
  assign PWRITE      = r_pwrite;
  assign PWDATA      = r_pwdata;
  assign PSEL        = (r_state != IDLE);
  assign PENABLE     = (r_state == ACCESS);
  assign rsp_valid   = r_rsp_valid;
  assign rsp_write   = r_rsp_write;
  assign rsp_rdata   = r_rsp_rdata;
  assign busy        = !w_empty || (r_state != IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed and random commands checked every cycle
// against a schedule model (SETUP cycle = max(accept+2, previous SETUP+2)).
module tb_apb_cmd_master;
  import apb_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 20;
  localparam int DEPTH = 4;
  localparam int MAXC  = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic [AW-1:0] PADDR;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          rsp_valid;
  logic          rsp_write;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic [1:0]    o_dbg_state;

  always #5 clk = ~clk;

  apb_cmd_master #(
    .AMBA_WORD       (DW),
    .AMBA_ADDR_WIDTH (AW),
    .CMD_DEPTH       (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .PADDR       (PADDR),
    .PSEL        (PSEL),
    .PENABLE     (PENABLE),
    .PWRITE      (PWRITE),
    .PWDATA      (PWDATA),
    .PRDATA      (PRDATA),
    .rsp_valid   (rsp_valid),
    .rsp_write   (rsp_write),
    .rsp_rdata   (rsp_rdata),
    .busy        (busy),
    .o_dbg_state (o_dbg_state)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n        = 0;

  // Reference schedule: one entry per accepted command since the last reset.
  logic          m_w   [MAXC];
  logic [AW-1:0] m_a   [MAXC];
  logic [DW-1:0] m_d   [MAXC];
  logic [DW-1:0] m_r   [MAXC];
  int            m_acc [MAXC];
  int            m_s   [MAXC];

  function automatic int occ(int t);
    int c = 0;
    for (int k = 0; k < n; k++) begin
      if (m_acc[k] < t) c++;
      if (m_s[k] <= t)  c--;
    end
    return c;
  endfunction

  function automatic int find_xfer(int t);
    for (int k = 0; k < n; k++)
      if (t >= m_s[k] && t <= m_s[k] + 1) return k;
    return -1;
  endfunction

  function automatic int find_rsp(int t);
    for (int k = 0; k < n; k++)
      if (t == m_s[k] + 2) return k;
    return -1;
  endfunction

  function automatic int last_before(int t);
    int h = -1;
    for (int k = 0; k < n; k++)
      if (m_s[k] < t) h = k;
    return h;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cyc=%0d obs=%0h exp=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle();
    int k;
    int r;
    int h;
    apb_state_e exp_st;
    k = find_xfer(cyc);
    r = find_rsp(cyc);
    h = last_before(cyc);
    if (k >= 0) begin
      exp_st = (cyc == m_s[k]) ? SETUP : ACCESS;
      chk("psel", PSEL, 1'b1);
      chk("penable", PENABLE, cyc == m_s[k] + 1);
      chk("paddr", PADDR, m_a[k]);
      chk("pwrite", PWRITE, m_w[k]);
      if (m_w[k]) chk("pwdata", PWDATA, m_d[k]);
    end else begin
      exp_st = IDLE;
      chk("psel_idle", PSEL, 1'b0);
      chk("penable_idle", PENABLE, 1'b0);
      if (h >= 0) begin
        chk("paddr_hold", PADDR, m_a[h]);
        chk("pwrite_hold", PWRITE, m_w[h]);
        if (m_w[h]) chk("pwdata_hold", PWDATA, m_d[h]);
      end else begin
        chk("paddr_rst", PADDR, '0);
        chk("pwrite_rst", PWRITE, 1'b0);
        chk("pwdata_rst", PWDATA, '0);
      end
    end
    chk("state", o_dbg_state, exp_st);
    chk("rsp_valid", rsp_valid, r >= 0);
    if (r >= 0) begin
      chk("rsp_write", rsp_write, m_w[r]);
      chk("rsp_rdata", rsp_rdata, m_w[r] ? '0 : m_r[r]);
    end
    chk("busy", busy, (occ(cyc) > 0) || (k >= 0));
  endtask

  // One clock cycle: check outputs, drive slave and command, advance.
  task automatic cycle(input logic v, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] rd,
                       output logic acc);
    int   k;
    int   prev;
    logic exp_rdy;
    check_cycle();
    k = find_xfer(cyc);
    if (k >= 0 && cyc == m_s[k] + 1 && !m_w[k]) PRDATA = m_r[k];
    else                                        PRDATA = $urandom;
    cmd_valid = v;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    exp_rdy   = !rst && (occ(cyc) < DEPTH);
    #1;
    chk("cmd_ready", cmd_ready, exp_rdy);
    acc = v && exp_rdy;
    if (acc) begin
      prev     = (n > 0) ? m_s[n-1] : -100;
      m_acc[n] = cyc;
      m_s[n]   = (cyc + 2 > prev + 2) ? cyc + 2 : prev + 2;
      m_w[n]   = w;
      m_a[n]   = a;
      m_d[n]   = d;
      m_r[n]   = rd;
      n++;
    end
    @(posedge clk);
    if (rst) n = 0;
    cyc++;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic offer(input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d, input logic [DW-1:0] rd);
    logic acc = 1'b0;
    for (int i = 0; i < 20 && !acc; i++) cycle(1'b1, w, a, d, rd, acc);
    chk("offer_accepted", acc, 1'b1);
  endtask

  task automatic drain();
    logic acc;
    int   i = 0;
    while (i < 60 && (occ(cyc) > 0 || find_xfer(cyc) >= 0 || find_rsp(cyc) >= 0)) begin
      cycle(1'b0, 1'b0, '0, '0, '0, acc);
      i++;
    end
    chk("drain_done", i < 60, 1'b1);
  endtask

  initial begin
    logic acc;
    int   k;
    logic found;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    PRDATA    = '0;
    repeat (3) @(negedge clk);

    chk("rst_psel", PSEL, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_paddr", PADDR, '0);
    chk("rst_pwrite", PWRITE, 1'b0);
    chk("rst_pwdata", PWDATA, '0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_write", rsp_write, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, '0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", cmd_ready, 1'b1);
    #1;

    // Single write then single read.
    offer(1'b1, 20'h00010, 32'hDEADBEEF, 32'h0);
    drain();
    offer(1'b0, 20'h00004, 32'h0, 32'h12345678);
    drain();

    // Burst of 6 offered back-to-back.
    for (int i = 0; i < 6; i++) offer(1'($urandom), AW'($urandom), $urandom, $urandom);
    drain();

    // 10 back-to-back commands: fills the FIFO, exercises full-with-pop and wrap.
    for (int i = 0; i < 10; i++) offer(1'($urandom), AW'($urandom), $urandom, $urandom);
    drain();

    // Reset during ACCESS with two commands still queued.
    for (int i = 0; i < 3; i++) offer(1'b1, AW'(20'h100 + i), $urandom, $urandom);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      k = find_xfer(cyc);
      if (k >= 0 && cyc == m_s[k] + 1 && occ(cyc) >= 2) found = 1'b1;
      else cycle(1'b0, 1'b0, '0, '0, '0, acc);
    end
    chk("rst_point_found", found, 1'b1);
    rst = 1'b1;
    cycle(1'b1, 1'b1, 20'h00BAD, 32'hBAD0BAD0, '0, acc);
    rst = 1'b0;
    chk("abort_psel", PSEL, 1'b0);
    chk("abort_penable", PENABLE, 1'b0);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_busy", busy, 1'b0);
    repeat (8) cycle(1'b0, 1'b0, '0, '0, '0, acc);

    // Random traffic with a mostly-busy offer rate.
    for (int i = 0; i < 200; i++)
      cycle($urandom_range(0, 3) != 0, 1'($urandom), AW'($urandom), $urandom, $urandom, acc);
    drain();
    repeat (3) cycle(1'b0, 1'b0, '0, '0, '0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
